// File: rtl/ebi_pkg.sv
// ebi_pkg: opcodes, FSM state encoding and grant sources shared by the EBI controller and transceiver.
package ebi_pkg;

    typedef enum logic [3:0] {
        OP_RD_REQ   = 4'h0,
        OP_WR_REQ   = 4'h1,
        OP_WR_PTL   = 4'h2,
        OP_SNP_RSP  = 4'h3,
        OP_SNP_DATA = 4'h4,
        OP_SNP_REQ  = 4'h6,
        OP_RD_RESP  = 4'h7,
        OP_ACK      = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RCV_HDR,
        ST_RCV,
        ST_RCV_LAST,
        ST_RCV_HOLD,
        ST_SEND_LOAD,
        ST_SEND,
        ST_TURN
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ACK,
        SRC_RD,
        SRC_SNP
    } src_e;

    // Received write requests must be acknowledged by an ACK send.
    function automatic logic is_write(input logic [3:0] op);
        return (op == OP_WR_REQ) || (op == OP_WR_PTL);
    endfunction

    function automatic logic [3:0] src_opcode(input src_e s);
        return (s == SRC_ACK) ? OP_ACK : (s == SRC_SNP) ? OP_SNP_REQ : OP_RD_RESP;
    endfunction

endpackage

// File: rtl/ebi_rr_arb2.sv
// ebi_rr_arb2: two-way round-robin arbiter; priority moves away from a source only once its send completes.
module ebi_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ptr_q : req[1];
        ptr_d     = done ? ~done_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/outer_ebi_ctrl.sv
// outer_ebi_ctrl: sequences the EBI transceiver between receiving transactions and sending
// read responses, snoop requests and write ACKs; receive always wins over a pending send.
module outer_ebi_ctrl
    import ebi_pkg::*;
#(
    parameter int EBI_WIDTH          = 16,
    parameter int RCV_TIMEOUT        = 255,
    parameter int SEND_BUFFER_LENGTH = 608
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          trx_rcv_start,
    input  logic                          trx_rcv_done,
    input  logic                          trx_send_done,
    input  logic [3:0]                    rcv_opcode,
    output logic [3:0]                    opcode,
    output logic                          is_counter_reload,
    output logic                          is_counter_ena,
    output logic                          is_rd_rcv,
    output logic                          is_send_mode,
    input  logic                          rd_resp_valid,
    output logic                          rd_resp_ready,
    input  logic [SEND_BUFFER_LENGTH-1:0] rd_resp_data,
    input  logic                          snp_req_valid,
    output logic                          snp_req_ready,
    input  logic [SEND_BUFFER_LENGTH-1:0] snp_req_data,
    output logic [SEND_BUFFER_LENGTH-1:0] send_data,
    output logic                          rcv_valid,
    input  logic                          rcv_ready,
    output logic [3:0]                    rcv_type,
    output logic                          rcv_err
);

    localparam int TW = $clog2(RCV_TIMEOUT + 1);

    if (SEND_BUFFER_LENGTH % EBI_WIDTH != 0) begin : g_bad_width
        $error("SEND_BUFFER_LENGTH must be a multiple of EBI_WIDTH");
    end

    state_e                        state_q, state_d;
    src_e                          src_q, src_d;
    logic [TW-1:0]                 cnt_q, cnt_d;
    logic [3:0]                    rcv_type_q, rcv_type_d;
    logic [3:0]                    opcode_q, opcode_d;
    logic [SEND_BUFFER_LENGTH-1:0] send_data_q, send_data_d;
    logic                          ack_q, ack_d;
    logic                          gnt_valid, gnt_idx, arb_done;

    ebi_rr_arb2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       ({snp_req_valid, rd_resp_valid}),
        .done      (arb_done),
        .done_idx  (src_q == SRC_SNP),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d           = state_q;
        src_d             = src_q;
        cnt_d             = cnt_q;
        rcv_type_d        = rcv_type_q;
        opcode_d          = opcode_q;
        send_data_d       = send_data_q;
        ack_d             = ack_q;
        is_counter_reload = 1'b0;
        is_counter_ena    = 1'b0;
        is_rd_rcv         = 1'b0;
        is_send_mode      = 1'b0;
        rd_resp_ready     = 1'b0;
        snp_req_ready     = 1'b0;
        rcv_valid         = 1'b0;
        rcv_err           = 1'b0;
        arb_done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trx_rcv_start) begin
                    state_d = ST_RCV_HDR;
                end else if (ack_q || gnt_valid) begin
                    // Payload and opcode are captured here and held until the send retires.
                    src_d       = ack_q ? SRC_ACK : (gnt_idx ? SRC_SNP : SRC_RD);
                    opcode_d    = src_opcode(src_d);
                    send_data_d = ack_q ? '0 : (gnt_idx ? snp_req_data : rd_resp_data);
                    state_d     = ST_SEND_LOAD;
                end
            end
            ST_RCV_HDR: begin
                is_counter_reload = 1'b1;
                rcv_type_d        = rcv_opcode;
                cnt_d             = '0;
                state_d           = ST_RCV;
            end
            ST_RCV: begin
                is_counter_ena = 1'b1;
                is_rd_rcv      = 1'b1;
                cnt_d          = cnt_q + TW'(1);
                if (trx_rcv_done) begin
                    state_d = ST_RCV_LAST;
                end else if (cnt_q == TW'(RCV_TIMEOUT)) begin
                    rcv_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RCV_LAST: begin
                is_rd_rcv = 1'b1;
                state_d   = ST_RCV_HOLD;
            end
            ST_RCV_HOLD: begin
                rcv_valid = 1'b1;
                if (rcv_ready) begin
                    ack_d   = ack_q | is_write(rcv_type_q);
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_LOAD: begin
                is_counter_reload = 1'b1;
                state_d           = ST_SEND;
            end
            ST_SEND: begin
                is_send_mode   = 1'b1;
                is_counter_ena = 1'b1;
                state_d        = trx_send_done ? ST_TURN : ST_SEND;
            end
            ST_TURN: begin
                rd_resp_ready = (src_q == SRC_RD);
                snp_req_ready = (src_q == SRC_SNP);
                arb_done      = (src_q == SRC_RD) || (src_q == SRC_SNP);
                ack_d         = ack_q && (src_q != SRC_ACK);
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_NONE;
            cnt_q       <= '0;
            rcv_type_q  <= '0;
            opcode_q    <= '0;
            send_data_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            rcv_type_q  <= rcv_type_d;
            opcode_q    <= opcode_d;
            send_data_q <= send_data_d;
            ack_q       <= ack_d;
        end
    end

    assign opcode    = opcode_q;
    assign send_data = send_data_q;
    assign rcv_type  = rcv_type_q;

endmodule
